// File: rtl/fbrc_sync.sv
// rtl/fbrc_sync.sv - synchronous free-running binary up-counter (optional tc output via FBRC_SYNC_TC_EN)
module fbrc_sync #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset
`ifdef FBRC_SYNC_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] toggle;
    logic             at_last;

    // Bit i toggles only when every lower bit is 1 (T-flip-flop chain).
    assign toggle[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign toggle[i] = &out[i-1:0];
    end

    assign at_last = (out == LAST);

    // All bits update together; terminal count loads 0 so truncated moduli wrap cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else if (at_last) begin
            out <= '0;
        end else begin
            out <= out ^ toggle;
        end
    end

`ifdef FBRC_SYNC_TC_EN
    assign tc = reset & at_last;
`endif

endmodule

// File: tb/tb_fbrc_sync.sv
// tb/tb_fbrc_sync.sv - directed self-checking bench for fbrc_sync
module tb_fbrc_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] out16;
    logic [3:0] out10;
    int         vec  = 0;
    int         miss = 0;
    int         m16  = 0;
    int         m10  = 0;

`ifdef FBRC_SYNC_TC_EN
    logic tc16, tc10;
`endif

    fbrc_sync #(.WIDTH(4)) dut16 (
        .out   (out16),
        .clk   (clk),
        .reset (reset)
`ifdef FBRC_SYNC_TC_EN
        ,
        .tc    (tc16)
`endif
    );

    fbrc_sync #(.WIDTH(4), .MODULUS(10)) dut10 (
        .out   (out10),
        .clk   (clk),
        .reset (reset)
`ifdef FBRC_SYNC_TC_EN
        ,
        .tc    (tc10)
`endif
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_m16"}, int'(out16), m16);
        check({tag, "_m10"}, int'(out10), m10);
`ifdef FBRC_SYNC_TC_EN
        check({tag, "_tc16"}, int'(tc16), (reset && m16 == 15) ? 1 : 0);
        check({tag, "_tc10"}, int'(tc10), (reset && m10 == 9) ? 1 : 0);
`endif
    endtask

    task automatic edge_step(input string tag);
        @(posedge clk);
        m16 = (m16 + 1) % 16;
        m10 = (m10 + 1) % 10;
        #1;
        check_both(tag);
    endtask

    initial begin
        // Reset held low across clock edges.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check_both("reset_async");
        @(posedge clk);
        #1 check_both("reset_hold_edge");
        #4 check_both("reset_15ns");

        // Release between edges, then count 1..5.
        reset = 1'b1;
        #1 check_both("release");
        for (int k = 0; k < 5; k++) edge_step("count5");

        // Re-reset mid-cycle, then a full 16-edge run with wrap.
        #5 reset = 1'b0;
        m16 = 0;
        m10 = 0;
        #1 check_both("reset_mid");
        #1 reset = 1'b1;
        for (int k = 0; k < 16; k++) edge_step("wrap16");
        check("wrap16_final", int'(out16), 0);

        // Count to 9, reset between edges, hold through an edge, release.
        for (int k = 0; k < 9; k++) edge_step("to9");
        check("at9", int'(out16), 9);
        #5 reset = 1'b0;
        m16 = 0;
        m10 = 0;
        #1 check_both("reset_at9");
        @(posedge clk);
        #1 check_both("reset_at9_edge");
        #3 reset = 1'b1;
        edge_step("after_reset9");
        check("after_reset9_one", int'(out16), 1);

        // Truncated modulus over 30 edges: never above 9.
        for (int k = 0; k < 30; k++) begin
            edge_step("mod10");
            check("mod10_range", (out10 <= 4'd9) ? 1 : 0, 1);
        end

        // Reset asserted exactly on a clock edge wins.
        @(posedge clk);
        reset = 1'b0;
        m16 = 0;
        m10 = 0;
        #1 check_both("reset_on_edge");
        #3 reset = 1'b1;
        edge_step("resume");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
